rv_writeback: RTL and testbench
===============================

# rv_writeback

Writeback controller for the RV32I core: it drives the register file's write port (regwr, inst, wrdata). It accepts one retired instruction at a time from execute and picks the result source (ALU result, PC+4, or load data). For loads it waits for the data-memory response, then aligns and sign/zero-extends the data. Finally it issues a single-cycle register write.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT_MEM before abort; only used with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wb_req  in  1  execute presents an instruction for writeback.
- wb_ready  out  1  high only in IDLE; a request is accepted when wb_req && wb_ready.
- inst  in  32  retired instruction; fields used: opcode [6:0], rd [11:7], funct3 [14:12].
- alu_result  in  32  ALU result; for loads this is the effective address.
- pc  in  32  PC of the retired instruction.
- mem_rvalid  in  1  data-memory read response valid.
- mem_rdata  in  32  aligned 32-bit word containing the loaded data.
- regwr  out  1  register-file write enable.
- wr_inst  out  32  instruction word passed to the register file; rd is taken from [11:7].
- wrdata  out  32  write data.
- wb_done  out  1  one-cycle pulse when the instruction retires.
- wb_err  out  1  one-cycle load-timeout pulse; constant 0 without WB_TIMEOUT_EN.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- On acceptance, latch inst, alu_result and pc, then classify the opcode:
  - 0110011, 0010011, 0110111 (LUI), 0010111 (AUIPC): write alu_result. Go to WRITE.
  - 1101111 (JAL), 1100111 (JALR): write pc+4, modulo 2^32 (0xFFFFFFFC+4 = 0x00000000). Go to WRITE.
  - 0000011 (LOAD): go to WAIT_MEM.
  - Store, branch, fence, system or unknown opcodes: go to WRITE with no write.
- WAIT_MEM: on mem_rvalid, capture the extracted value and go to WRITE. Extraction uses off = latched alu_result[1:0]:
  - LB (000): mem_rdata byte off, sign-extended.
  - LBU (100): mem_rdata byte off, zero-extended.
  - LH (001): halfword at off[1], sign-extended; off[0] is ignored.
  - LHU (101): halfword at off[1], zero-extended; off[0] is ignored.
  - LW (010) and funct3 011/110/111: full word; off is ignored.
- WRITE: exactly one cycle, then return to IDLE.
  - regwr=1 only if the instruction writes and rd≠0.
  - wr_inst = latched inst; wrdata = result.
  - wb_done=1 for every instruction, including non-writing ones and rd=0.
- Outside WRITE: regwr=0, wb_done=0, wb_err=0. wrdata and wr_inst hold their last value.
- mem_rvalid is ignored in IDLE and WRITE, including on the acceptance cycle.
- wb_req is ignored while wb_ready=0.
- Reset values: state IDLE, regwr 0, wb_done 0, wb_err 0, wrdata 0, wr_inst 0, timeout counter 0.
- rst asserted in WAIT_MEM or WRITE: abandon the instruction with no write and no wb_done.

## Timing
- regwr, wrdata, wr_inst, wb_done and wb_err are registered. wb_ready is decoded from state.
- Non-load latency: accepted at edge N; regwr high during cycle N+1; the register file commits at edge N+2.
- Load latency: mem_rvalid sampled high at edge M; regwr high during cycle M+1.
- Earliest next acceptance is the first edge after WRITE. Throughput is 1 instruction per 2 cycles for non-loads and ≥3 cycles for loads.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_MEM and increments each cycle there without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, go to WRITE with regwr=0, wb_done=1, wb_err=1.
  - If mem_rvalid arrives on the same cycle the limit is hit, the data wins and wb_err=0.
- WB_TIMEOUT_EN undefined:
  - No counter; WAIT_MEM waits indefinitely.
  - wb_err is tied to 0 and the port remains present.

## Test plan
- ADD with rd=5, alu_result=0x12345678: regwr=1 exactly one cycle after acceptance, wr_inst[11:7]=5, wrdata=0x12345678, wb_done=1 in the same cycle; wb_ready low for exactly 1 cycle.
- JAL rd=1, pc=0x00000100: wrdata=0x00000104. Repeat with pc=0xFFFFFFFC: wrdata=0x00000000.
- Load extraction with mem_rdata=0x80FF7F01:
  - LB off=3 → 0xFFFFFF80.
  - LBU off=1 → 0x0000007F.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=0 → 0x00007F01.
  - LW off=1 → 0x80FF7F01.
  - mem_rvalid delayed 4 cycles → regwr exactly 1 cycle after mem_rvalid.
- SW, then ADDI with rd=0: regwr stays 0, wb_done pulses once per instruction. mem_rvalid pulses in IDLE leave the outputs unchanged.
- rst pulsed while in WAIT_MEM: all outputs 0 the next cycle, no write when mem_rvalid later arrives, wb_ready=1.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no mem_rvalid: wb_err=wb_done=1 with regwr=0 after 16 WAIT_MEM cycles. Repeat with mem_rvalid on the 16th cycle: normal write, wb_err=0.

Source files
------------

// File: rtl/rv_writeback.sv
// RV32I writeback controller: picks the result source, waits for and extracts load data,
// and issues a single-cycle register-file write. Optional load timeout under WB_TIMEOUT_EN.
module rv_writeback #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_req,
    output logic        wb_ready,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        regwr,
    output logic [31:0] wr_inst,
    output logic [31:0] wrdata,
    output logic        wb_done,
    output logic        wb_err
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    state_t      state, state_nx;
    logic [31:0] inst_q;
    logic [1:0]  off_q;

    logic        enter_wr;
    logic        regwr_nx;
    logic        err_nx;
    logic [31:0] data_nx;
    logic [31:0] inst_nx;
    logic        tmo_hit;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    assign wb_ready = (state == IDLE);

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Held at zero outside WAIT_MEM, so it is always clear on entry.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_MEM)
            tmo_cnt <= '0;
        else if (!mem_rvalid)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        enter_wr = 1'b0;
        regwr_nx = 1'b0;
        err_nx   = 1'b0;
        data_nx  = wrdata;
        inst_nx  = wr_inst;
        case (state)
            IDLE: begin
                if (wb_req) begin
                    inst_nx = inst;
                    case (inst[6:0])
                        OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC: begin
                            state_nx = WRITE;
                            enter_wr = 1'b1;
                            regwr_nx = (inst[11:7] != 5'd0);
                            data_nx  = alu_result;
                        end
                        OP_JAL, OP_JALR: begin
                            state_nx = WRITE;
                            enter_wr = 1'b1;
                            regwr_nx = (inst[11:7] != 5'd0);
                            data_nx  = pc + 32'd4;
                        end
                        OP_LOAD: state_nx = WAIT_MEM;
                        default: begin
                            state_nx = WRITE;
                            enter_wr = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                inst_nx = inst_q;
                // Data arriving on the limit cycle takes priority over the timeout.
                if (mem_rvalid) begin
                    state_nx = WRITE;
                    enter_wr = 1'b1;
                    regwr_nx = (inst_q[11:7] != 5'd0);
                    data_nx  = extract(inst_q[14:12], off_q, mem_rdata);
                end else if (tmo_hit) begin
                    state_nx = WRITE;
                    enter_wr = 1'b1;
                    err_nx   = 1'b1;
                end
            end
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            inst_q  <= '0;
            off_q   <= '0;
            regwr   <= 1'b0;
            wb_done <= 1'b0;
            wb_err  <= 1'b0;
            wrdata  <= '0;
            wr_inst <= '0;
        end else begin
            state   <= state_nx;
            regwr   <= regwr_nx;
            wb_done <= enter_wr;
            wb_err  <= err_nx;
            if (state == IDLE && wb_req) begin
                inst_q <= inst;
                off_q  <= alu_result[1:0];
            end
            if (enter_wr) begin
                wrdata  <= data_nx;
                wr_inst <= inst_nx;
            end
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// Directed self-checking bench for rv_writeback; timeout scenarios run when WB_TIMEOUT_EN is defined.
module tb_rv_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req;
    logic        wb_ready;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        regwr;
    logic [31:0] wr_inst;
    logic [31:0] wrdata;
    logic        wb_done;
    logic        wb_err;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] ADD_R5   = 32'h002082B3;
    localparam logic [31:0] JAL_R1   = 32'h000000EF;
    localparam logic [31:0] SW_I     = 32'h0020A023;
    localparam logic [31:0] ADDI_R0  = 32'h00108013;
    localparam logic [31:0] LOAD_R7  = 32'h00000383;

    rv_writeback #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .wb_req(wb_req), .wb_ready(wb_ready), .inst(inst),
        .alu_result(alu_result), .pc(pc), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .regwr(regwr), .wr_inst(wr_inst), .wrdata(wrdata), .wb_done(wb_done), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_req = 1'b0; inst = '0; alu_result = '0; pc = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        tests++; if (regwr !== 1'b0) begin fails++; $display("FAIL reset_regwr got=%b exp=0", regwr); end
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", wb_done); end
        tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", wb_err); end
        tests++; if (wrdata !== 32'h0) begin fails++; $display("FAIL reset_wrdata got=%h exp=0", wrdata); end
        tests++; if (wr_inst !== 32'h0) begin fails++; $display("FAIL reset_wrinst got=%h exp=0", wr_inst); end
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", wb_ready); end
    endtask

    task automatic test_alu();
        inst = ADD_R5; alu_result = 32'h12345678; pc = 32'h40; wb_req = 1'b1;
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL alu_ready_pre got=%b exp=1", wb_ready); end
        step();
        wb_req = 1'b0;
        tests++; if (regwr !== 1'b1) begin fails++; $display("FAIL alu_regwr got=%b exp=1", regwr); end
        tests++; if (wr_inst[11:7] !== 5'd5) begin fails++; $display("FAIL alu_rd got=%0d exp=5", wr_inst[11:7]); end
        tests++; if (wrdata !== 32'h12345678) begin fails++; $display("FAIL alu_wrdata got=%h exp=12345678", wrdata); end
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL alu_done got=%b exp=1", wb_done); end
        tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL alu_ready_busy got=%b exp=0", wb_ready); end
        step();
        tests++; if (regwr !== 1'b0) begin fails++; $display("FAIL alu_regwr_off got=%b exp=0", regwr); end
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL alu_done_off got=%b exp=0", wb_done); end
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL alu_ready_back got=%b exp=1", wb_ready); end
        tests++; if (wrdata !== 32'h12345678) begin fails++; $display("FAIL alu_wrdata_hold got=%h exp=12345678", wrdata); end
    endtask

    task automatic test_jal(input logic [31:0] pcv, input logic [31:0] exp);
        inst = JAL_R1; pc = pcv; alu_result = 32'hAAAA5555; wb_req = 1'b1;
        step();
        wb_req = 1'b0;
        tests++; if (regwr !== 1'b1) begin fails++; $display("FAIL jal_regwr got=%b exp=1", regwr); end
        tests++; if (wrdata !== exp) begin fails++; $display("FAIL jal_wrdata got=%h exp=%h", wrdata, exp); end
        step();
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [1:0] off, input int delay,
                             input logic [31:0] exp);
        inst = LOAD_R7 | (32'(f3) << 12); alu_result = 32'h00001000 | 32'(off); wb_req = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        wb_req = 1'b0; mem_rvalid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tests++; if (regwr !== 1'b0 || wb_ready !== 1'b0) begin
                fails++; $display("FAIL load_wait f3=%0d regwr=%b ready=%b exp 0/0", f3, regwr, wb_ready);
            end
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tests++; if (regwr !== 1'b1 || wb_done !== 1'b1) begin
            fails++; $display("FAIL load_regwr f3=%0d regwr=%b done=%b exp 1/1", f3, regwr, wb_done);
        end
        tests++; if (wrdata !== exp) begin
            fails++; $display("FAIL load_data f3=%0d off=%0d got=%h exp=%h", f3, off, wrdata, exp);
        end
        tests++; if (wr_inst !== (LOAD_R7 | (32'(f3) << 12))) begin
            fails++; $display("FAIL load_inst got=%h", wr_inst);
        end
        step();
    endtask

    task automatic test_no_write();
        // Known wrdata first, then stray mem_rvalid in IDLE must change nothing.
        inst = ADD_R5; alu_result = 32'h0BADF00D; wb_req = 1'b1;
        step(); wb_req = 1'b0; step();
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        step(); step();
        mem_rvalid = 1'b0;
        tests++; if (regwr !== 1'b0 || wb_done !== 1'b0 || wb_ready !== 1'b1) begin
            fails++; $display("FAIL idle_rvalid regwr=%b done=%b ready=%b exp 0/0/1", regwr, wb_done, wb_ready);
        end
        tests++; if (wrdata !== 32'h0BADF00D) begin fails++; $display("FAIL idle_rvalid_data got=%h exp=0badf00d", wrdata); end
        inst = SW_I; alu_result = 32'h2000; wb_req = 1'b1;
        step(); wb_req = 1'b0;
        tests++; if (regwr !== 1'b0 || wb_done !== 1'b1) begin
            fails++; $display("FAIL sw regwr=%b done=%b exp 0/1", regwr, wb_done);
        end
        step();
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL sw_done_once got=%b exp=0", wb_done); end
        inst = ADDI_R0; alu_result = 32'h77; wb_req = 1'b1;
        step(); wb_req = 1'b0;
        tests++; if (regwr !== 1'b0 || wb_done !== 1'b1) begin
            fails++; $display("FAIL addi_r0 regwr=%b done=%b exp 0/1", regwr, wb_done);
        end
        step();
    endtask

    task automatic test_rst_wait();
        inst = LOAD_R7 | (32'd2 << 12); alu_result = 32'h3000; wb_req = 1'b1;
        step(); wb_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (regwr !== 1'b0 || wb_done !== 1'b0 || wb_err !== 1'b0) begin
            fails++; $display("FAIL rst_wait_ctrl regwr=%b done=%b err=%b exp 0", regwr, wb_done, wb_err);
        end
        tests++; if (wrdata !== 32'h0 || wr_inst !== 32'h0) begin
            fails++; $display("FAIL rst_wait_data wrdata=%h wr_inst=%h exp 0", wrdata, wr_inst);
        end
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL rst_wait_ready got=%b exp=1", wb_ready); end
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_rvalid = 1'b0;
        step();
        tests++; if (regwr !== 1'b0 || wb_done !== 1'b0) begin
            fails++; $display("FAIL rst_wait_late regwr=%b done=%b exp 0/0", regwr, wb_done);
        end
    endtask

    task automatic test_back_to_back();
        inst = ADD_R5; alu_result = 32'hA0A0A0A0; wb_req = 1'b1;
        step();
        alu_result = 32'hCCCCCCCC;
        tests++; if (wrdata !== 32'hA0A0A0A0) begin fails++; $display("FAIL b2b_first got=%h exp=a0a0a0a0", wrdata); end
        step();
        alu_result = 32'hB1B1B1B1;
        tests++; if (regwr !== 1'b0 || wb_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_gap regwr=%b ready=%b exp 0/1", regwr, wb_ready);
        end
        step();
        wb_req = 1'b0;
        tests++; if (regwr !== 1'b1 || wrdata !== 32'hB1B1B1B1) begin
            fails++; $display("FAIL b2b_second regwr=%b got=%h exp=b1b1b1b1", regwr, wrdata);
        end
        step();
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout(input bit late_data);
        inst = LOAD_R7 | (32'd2 << 12); alu_result = 32'h4000; wb_req = 1'b1;
        step(); wb_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tests++; if (wb_done !== 1'b0 || wb_err !== 1'b0) begin
                fails++; $display("FAIL tmo_early cyc=%0d done=%b err=%b exp 0/0", i, wb_done, wb_err);
            end
            step();
        end
        mem_rvalid = late_data; mem_rdata = 32'h13572468;
        step();
        mem_rvalid = 1'b0;
        if (late_data) begin
            tests++; if (regwr !== 1'b1 || wb_err !== 1'b0 || wrdata !== 32'h13572468) begin
                fails++; $display("FAIL tmo_data_wins regwr=%b err=%b data=%h exp 1/0/13572468", regwr, wb_err, wrdata);
            end
        end else begin
            tests++; if (regwr !== 1'b0 || wb_err !== 1'b1 || wb_done !== 1'b1) begin
                fails++; $display("FAIL tmo_abort regwr=%b err=%b done=%b exp 0/1/1", regwr, wb_err, wb_done);
            end
        end
        step();
        tests++; if (wb_err !== 1'b0 || wb_ready !== 1'b1) begin
            fails++; $display("FAIL tmo_after err=%b ready=%b exp 0/1", wb_err, wb_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_jal(32'h00000100, 32'h00000104);
        test_jal(32'hFFFFFFFC, 32'h00000000);
        test_load(3'b000, 2'd3, 0, 32'hFFFFFF80);
        test_load(3'b100, 2'd1, 1, 32'h0000007F);
        test_load(3'b001, 2'd2, 0, 32'hFFFF80FF);
        test_load(3'b101, 2'd0, 2, 32'h00007F01);
        test_load(3'b010, 2'd1, 4, 32'h80FF7F01);
        test_no_write();
        test_rst_wait();
        test_back_to_back();
`ifdef WB_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
